// File: rtl/shift_register_sequencer_if.sv
// Byte handshake, serial drive and capture signals between a producer/shift register (master) and the sequencer (slave).
// par_out exists only when SHIFT_SEQ_PARITY_EN is defined.
interface shift_register_sequencer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             abort;
  logic             ser_out;
  logic             shift_en;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] rx_data;
  logic             done;
  logic             busy;
`ifdef SHIFT_SEQ_PARITY_EN
  logic             par_out;
`endif

  modport slave (
    input  tx_data, tx_valid, abort, sr_q,
    output tx_ready, ser_out, shift_en, rx_data, done, busy
`ifdef SHIFT_SEQ_PARITY_EN
    , output par_out
`endif
  );

  modport master (
    output tx_data, tx_valid, abort, sr_q,
    input  tx_ready, ser_out, shift_en, rx_data, done, busy
`ifdef SHIFT_SEQ_PARITY_EN
    , input par_out
`endif
  );
endinterface

// File: rtl/shift_register_sequencer.sv
// Serialises an accepted byte MSB-first into an external SIPO register, then captures its parallel output; done arrives
// WIDTH+2+GAP_CYCLES cycles after accept (+1 with SHIFT_SEQ_PARITY_EN); tx_ready is high only in IDLE, abort drops the frame.
module shift_register_sequencer #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 0
) (
  input logic                       clk,
  input logic                       reset,
  shift_register_sequencer_if.slave bus
);
  localparam int         CW       = $clog2(WIDTH) + 1;
  localparam int         IW       = $clog2(WIDTH);
  localparam logic [3:0] GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP,
    S_PARITY,
    S_CAPTURE
  } state_t;

`ifdef SHIFT_SEQ_PARITY_EN
  localparam state_t AFTER_GAP = S_PARITY;
`else
  localparam state_t AFTER_GAP = S_CAPTURE;
`endif
  localparam state_t AFTER_SHIFT = (GAP_CYCLES > 0) ? S_GAP : AFTER_GAP;

  state_t           r_state, w_nxt_state;
  logic [CW-1:0]    r_bit_cnt, w_nxt_bit_cnt;
  logic [3:0]       r_gap_cnt, w_nxt_gap_cnt;
  logic [WIDTH-1:0] r_hold;
  logic             w_load;
  logic [IW-1:0]    w_idx;
  logic             r_ser_out, w_nxt_ser_out;
  logic             r_shift_en, w_nxt_shift_en;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_done;
  logic             w_capture;

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_bit_cnt = r_bit_cnt;
    w_nxt_gap_cnt = r_gap_cnt;
    w_load        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.tx_valid && !bus.abort) begin
          w_nxt_state   = S_SHIFT;
          w_nxt_bit_cnt = '0;
          w_load        = 1'b1;
        end
      end
      S_SHIFT: begin
        w_nxt_bit_cnt = r_bit_cnt + 1'b1;
        if (r_bit_cnt == CW'(WIDTH - 1)) begin
          w_nxt_state   = AFTER_SHIFT;
          w_nxt_gap_cnt = '0;
        end
      end
      S_GAP: begin
        w_nxt_gap_cnt = r_gap_cnt + 1'b1;
        if (r_gap_cnt == GAP_LAST) w_nxt_state = AFTER_GAP;
      end
      S_PARITY:  w_nxt_state = S_CAPTURE;
      S_CAPTURE: w_nxt_state = S_IDLE;
      default:   w_nxt_state = S_IDLE;
    endcase
    if (r_state != S_IDLE && bus.abort) w_nxt_state = S_IDLE;

    // Serial outputs are registered, so they are derived from the state being entered.
    w_idx          = IW'(WIDTH - 1) - w_nxt_bit_cnt[IW-1:0];
    w_nxt_shift_en = (w_nxt_state == S_SHIFT);
    w_nxt_ser_out  = 1'b0;
    if (w_load)                        w_nxt_ser_out = bus.tx_data[WIDTH-1];
    else if (w_nxt_state == S_SHIFT)   w_nxt_ser_out = r_hold[w_idx];
  end

  assign w_capture = (r_state == S_CAPTURE) && !bus.abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_hold     <= '0;
      r_ser_out  <= 1'b0;
      r_shift_en <= 1'b0;
      r_rx_data  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_bit_cnt  <= w_nxt_bit_cnt;
      r_gap_cnt  <= w_nxt_gap_cnt;
      r_ser_out  <= w_nxt_ser_out;
      r_shift_en <= w_nxt_shift_en;
      r_done     <= w_capture;
      if (w_load)    r_hold    <= bus.tx_data;
      if (w_capture) r_rx_data <= bus.sr_q;
    end
  end

`ifdef SHIFT_SEQ_PARITY_EN
  logic r_par_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_par_out <= 1'b0;
    else        r_par_out <= (w_nxt_state == S_PARITY) ? ^r_hold : 1'b0;
  end

  assign bus.par_out = r_par_out;
`endif

  assign bus.tx_ready = (r_state == S_IDLE);
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.ser_out  = r_ser_out;
  assign bus.shift_en = r_shift_en;
  assign bus.rx_data  = r_rx_data;
  assign bus.done     = r_done;
endmodule

// File: tb/tb_shift_register_sequencer.sv
// Bench for shift_register_sequencer: two instances (GAP_CYCLES 0 and 2), each feeding a model SIPO register,
// checked every cycle against a frame-position model plus directed literal expectations.
module tb_shift_register_sequencer;
  localparam int W  = 8;
  localparam int G1 = 2;
`ifdef SHIFT_SEQ_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit run    = 1'b0;

  logic [W-1:0] d_data [2];
  logic         d_valid[2];
  logic         d_abort[2];
  logic [W-1:0] sr     [2];

  logic         o_ready[2], o_busy[2], o_ser[2], o_sen[2], o_done[2], o_par[2];
  logic [W-1:0] o_rx   [2];

  shift_register_sequencer_if #(.WIDTH(W)) if0 ();
  shift_register_sequencer_if #(.WIDTH(W)) if1 ();

  shift_register_sequencer #(.WIDTH(W), .GAP_CYCLES(0))  dut0 (.clk(clk), .reset(reset), .bus(if0));
  shift_register_sequencer #(.WIDTH(W), .GAP_CYCLES(G1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  assign if0.tx_data  = d_data[0];
  assign if0.tx_valid = d_valid[0];
  assign if0.abort    = d_abort[0];
  assign if0.sr_q     = sr[0];
  assign if1.tx_data  = d_data[1];
  assign if1.tx_valid = d_valid[1];
  assign if1.abort    = d_abort[1];
  assign if1.sr_q     = sr[1];

  assign o_ready[0] = if0.tx_ready;  assign o_ready[1] = if1.tx_ready;
  assign o_busy[0]  = if0.busy;      assign o_busy[1]  = if1.busy;
  assign o_ser[0]   = if0.ser_out;   assign o_ser[1]   = if1.ser_out;
  assign o_sen[0]   = if0.shift_en;  assign o_sen[1]   = if1.shift_en;
  assign o_done[0]  = if0.done;      assign o_done[1]  = if1.done;
  assign o_rx[0]    = if0.rx_data;   assign o_rx[1]    = if1.rx_data;
`ifdef SHIFT_SEQ_PARITY_EN
  assign o_par[0] = if0.par_out;
  assign o_par[1] = if1.par_out;
`else
  assign o_par[0] = 1'b0;
  assign o_par[1] = 1'b0;
`endif

  // External MSB-first left-shift register fed by each sequencer
  initial begin
    sr[0] = '0;
    sr[1] = '0;
  end
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (o_sen[i]) sr[i] <= {sr[i][W-2:0], o_ser[i]};
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Model: a frame is a position counter p (1 = first bit cycle); capture at p == flen, done the cycle after.
  bit           m_act [2] = '{0, 0};
  int           m_p   [2] = '{0, 0};
  logic [W-1:0] m_byte[2] = '{8'h00, 8'h00};
  logic [W-1:0] m_rx  [2] = '{8'h00, 8'h00};
  bit           m_done[2] = '{0, 0};

  function automatic int gap_of(input int i);
    return (i == 1) ? G1 : 0;
  endfunction

  function automatic int flen(input int i);
    return W + gap_of(i) + PAR + 1;
  endfunction

  always @(posedge clk or negedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_act[i]  <= 1'b0;
        m_p[i]    <= 0;
        m_rx[i]   <= '0;
        m_done[i] <= 1'b0;
      end else if (m_act[i]) begin
        if (d_abort[i]) m_act[i] <= 1'b0;
        else if (m_p[i] == flen(i)) begin
          m_act[i]  <= 1'b0;
          m_done[i] <= 1'b1;
          m_rx[i]   <= m_byte[i];
        end else m_p[i] <= m_p[i] + 1;
      end else begin
        m_done[i] <= 1'b0;
        if (d_valid[i] && !d_abort[i]) begin
          m_act[i]  <= 1'b1;
          m_p[i]    <= 1;
          m_byte[i] <= d_data[i];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      for (int i = 0; i < 2; i++) begin
        logic e_sen, e_ser, e_par;
        e_sen = m_act[i] && (m_p[i] <= W);
        e_ser = e_sen ? m_byte[i][W - m_p[i]] : 1'b0;
        e_par = (PAR == 1 && m_act[i] && m_p[i] == W + gap_of(i) + 1) ? ^m_byte[i] : 1'b0;
        chk($sformatf("model_busy%0d", i),  o_busy[i],  m_act[i]);
        chk($sformatf("model_ready%0d", i), o_ready[i], !m_act[i]);
        chk($sformatf("model_sen%0d", i),   o_sen[i],   e_sen);
        chk($sformatf("model_ser%0d", i),   o_ser[i],   e_ser);
        chk($sformatf("model_par%0d", i),   o_par[i],   e_par);
        chk($sformatf("model_done%0d", i),  o_done[i],  m_done[i]);
        chk($sformatf("model_rx%0d", i),    o_rx[i],    m_rx[i]);
      end
    end
  end

  // Sends one byte; lat is the done cycle relative to the accept edge (done in cycle T+lat), -1 on timeout.
  task automatic run_frame(input int idx, input logic [W-1:0] b, output int lat,
                           output logic [W-1:0] bits, output int nsh, output int npar);
    int t0;
    d_data[idx]  = b;
    d_valid[idx] = 1'b1;
    @(posedge clk); #1;
    t0           = cyc;
    d_valid[idx] = 1'b0;
    d_data[idx]  = '0;
    lat  = -1;
    bits = '0;
    nsh  = 0;
    npar = 0;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      if (o_sen[idx]) begin
        bits = {bits[W-2:0], o_ser[idx]};
        nsh++;
      end
      if (o_par[idx]) npar++;
      if (o_done[idx]) lat = cyc - t0 + 1;
      else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_done(input int idx, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(posedge clk); #1;
      if (o_done[idx]) seen = 1'b1;
    end
  endtask

  initial begin
    int           lat, nsh, npar, ndone;
    logic [W-1:0] bits;
    bit           seen;
    for (int i = 0; i < 2; i++) begin
      d_data[i]  = '0;
      d_valid[i] = 1'b0;
      d_abort[i] = 1'b0;
    end
    @(posedge clk); #1;
    run = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    @(posedge clk); #1;
    chk("rst_tx_ready", o_ready[0], 1'b1);
    chk("rst_busy",     o_busy[0],  1'b0);
    chk("rst_shift_en", o_sen[0],   1'b0);
    chk("rst_ser_out",  o_ser[0],   1'b0);
    chk("rst_rx_data",  o_rx[0],    8'h00);
    chk("rst_done",     o_done[0],  1'b0);

    run_frame(0, 8'hB5, lat, bits, nsh, npar);
    chk("b5_latency",  lat,      10 + PAR);
    chk("b5_bits",     bits,     8'hB5);
    chk("b5_nshift",   nsh,      8);
    chk("b5_parity",   npar,     PAR);
    chk("b5_rx",       o_rx[0],  8'hB5);
    chk("b5_ready_on_done", o_ready[0], 1'b1);

    d_data[0]  = 8'h3C;
    d_valid[0] = 1'b1;
    @(posedge clk); #1;
    d_data[0] = 8'hA5;
    wait_done(0, seen);
    chk("b2b_first_done", seen, 1'b1);
    chk("b2b_first_rx",   o_rx[0],    8'h3C);
    chk("b2b_ready",      o_ready[0], 1'b1);
    @(posedge clk); #1;
    chk("b2b_second_busy", o_busy[0], 1'b1);
    chk("b2b_second_sen",  o_sen[0],  1'b1);
    chk("b2b_second_msb",  o_ser[0],  1'b1);
    d_valid[0] = 1'b0;
    wait_done(0, seen);
    chk("b2b_second_done", seen,    1'b1);
    chk("b2b_second_rx",   o_rx[0], 8'hA5);

    d_data[0]  = 8'hFF;
    d_valid[0] = 1'b1;
    @(posedge clk); #1;
    d_valid[0] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("abort_pre_sen", o_sen[0], 1'b1);
    d_abort[0] = 1'b1;
    @(posedge clk); #1;
    d_abort[0] = 1'b0;
    chk("abort_sen",  o_sen[0],  1'b0);
    chk("abort_ser",  o_ser[0],  1'b0);
    chk("abort_busy", o_busy[0], 1'b0);
    ndone = 0;
    repeat (14) begin
      @(posedge clk); #1;
      if (o_done[0]) ndone++;
    end
    chk("abort_no_done", ndone,   0);
    chk("abort_rx_kept", o_rx[0], 8'hA5);

    d_data[0]  = 8'h96;
    d_valid[0] = 1'b1;
    @(posedge clk); #1;
    d_valid[0] = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("rstmid_pre_busy", o_busy[0], 1'b1);
    chk("rstmid_bit5",     o_ser[0],  1'b0);
    reset = 1'b0;
    #1;
    chk("rstmid_sen",   o_sen[0],   1'b0);
    chk("rstmid_busy",  o_busy[0],  1'b0);
    chk("rstmid_ready", o_ready[0], 1'b1);
    chk("rstmid_rx",    o_rx[0],    8'h00);
    chk("rstmid_done",  o_done[0],  1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_after_ready", o_ready[0], 1'b1);
    chk("rstmid_after_busy",  o_busy[0],  1'b0);

    run_frame(1, 8'hB5, lat, bits, nsh, npar);
    chk("gap_latency", lat,      12 + PAR);
    chk("gap_bits",    bits,     8'hB5);
    chk("gap_nshift",  nsh,      8);
    chk("gap_parity",  npar,     PAR);
    chk("gap_rx",      o_rx[1],  8'hB5);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
